score_keeper: RTL and testbench

- Upstream producer of the `score` and `comboCount` values shown by the seven-segment display stage.
- Judges player button presses against the arrow stream issued by the game sequencer (the same `next_arrow` code the display consumes).
- Maintains saturating decimal-range score and combo counters.
- Emits one-cycle hit/miss strobes for feedback logic.

---
 rtl/score_keeper_pkg.sv | 26 ++
 rtl/score_keeper_sat_add14.sv | 15 +
 rtl/score_keeper.sv | 167 ++++++++++++++++
 tb/tb_score_keeper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared game-state, arrow and judge FSM definitions
package score_keeper_pkg;

    localparam int STATE_BITS = 2;

    localparam logic [STATE_BITS:0] STATE_MENU  = 3'd0;
    localparam logic [STATE_BITS:0] STATE_GAME  = 3'd1;
    localparam logic [STATE_BITS:0] STATE_PAUSE = 3'd2;
    localparam logic [STATE_BITS:0] STATE_OVER  = 3'd3;

    // [3:0] one-hot direction, [4] marks a rest beat with no arrow
    localparam logic [4:0] ARROW_UP    = 5'b00001;
    localparam logic [4:0] ARROW_DOWN  = 5'b00010;
    localparam logic [4:0] ARROW_LEFT  = 5'b00100;
    localparam logic [4:0] ARROW_RIGHT = 5'b01000;
    localparam logic [4:0] ARROW_REST  = 5'b10000;

    localparam logic [13:0] MAX_VAL = 14'd9999;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_ARMED = 2'd1,
        FSM_DONE  = 2'd2
    } fsm_e;

endpackage

// File: rtl/score_keeper_sat_add14.sv
// rtl/score_keeper_sat_add14.sv - 14-bit adder clamped to the four-digit display limit
module sat_add14
    import score_keeper_pkg::*;
(
    input  logic [13:0] a_i,
    input  logic [13:0] b_i,
    output logic [13:0] y_o
);

    logic [14:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};
    assign y_o = (sum > {1'b0, MAX_VAL}) ? MAX_VAL : sum[13:0];

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - judges button presses against issued arrows, keeps score/combo
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WINDOW_CYCLES = 2000000,
    parameter int HIT_POINTS    = 10,
    parameter int BONUS_THRESH  = 10,
    parameter int BONUS_POINTS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STATE_BITS:0]   state,
    input  logic                  beat,
    input  logic [4:0]            arrow,
    input  logic [3:0]            btn,
    output logic [13:0]           score,
    output logic [13:0]           comboCount,
    output logic [13:0]           max_combo,
    output logic                  hit,
    output logic                  miss
);

    localparam int CW = $clog2(WINDOW_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW_CYCLES - 1);

    fsm_e                  fsm_q, fsm_d;
    logic [3:0]            target_q, target_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            btn_q;
    logic [STATE_BITS:0]   prev_state_q;
    logic [13:0]           score_q, score_d;
    logic [13:0]           combo_q, combo_d;
    logic [13:0]           max_q, max_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;

    logic [3:0]            press;
    logic                  judge_hit;
    logic                  judge_miss;
    logic                  clear;
    logic [13:0]           combo_base;
    logic [13:0]           hit_pts;
    logic [13:0]           score_sum;
    logic [13:0]           combo_inc;

    assign press = btn & ~btn_q;

    // A beat always retires whatever arrow was pending; a press in the beat
    // cycle belongs to the newly issued arrow.
    always_comb begin
        fsm_d      = fsm_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        clear      = 1'b0;
        if (state != STATE_GAME) begin
            fsm_d = FSM_IDLE;
        end else if (prev_state_q != STATE_GAME && prev_state_q != STATE_PAUSE) begin
            clear    = 1'b1;
            fsm_d    = FSM_IDLE;
            target_d = 4'b0;
            cnt_d    = '0;
        end else if (beat) begin
            judge_miss = (fsm_q == FSM_ARMED);
            if (arrow[4]) begin
                fsm_d    = FSM_DONE;
                target_d = 4'b0;
            end else begin
                target_d = arrow[3:0];
                cnt_d    = '0;
                if (press == 4'b0) begin
                    fsm_d = FSM_ARMED;
                end else begin
                    fsm_d = FSM_DONE;
                    if (press == arrow[3:0]) judge_hit  = 1'b1;
                    else                     judge_miss = 1'b1;
                end
            end
        end else if (fsm_q == FSM_ARMED) begin
            if (press != 4'b0) begin
                fsm_d = FSM_DONE;
                if (press == target_q) judge_hit  = 1'b1;
                else                   judge_miss = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
                fsm_d      = FSM_DONE;
                judge_miss = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Miss is applied before hit, so a combined result restarts the combo at 1.
    assign combo_base = judge_miss ? 14'd0 : combo_q;
    assign hit_pts    = (combo_base >= 14'(BONUS_THRESH)) ? 14'(HIT_POINTS + BONUS_POINTS)
                                                          : 14'(HIT_POINTS);

    sat_add14 u_score_add (
        .a_i (score_q),
        .b_i (hit_pts),
        .y_o (score_sum)
    );

    sat_add14 u_combo_add (
        .a_i (combo_base),
        .b_i (14'd1),
        .y_o (combo_inc)
    );

    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (clear) begin
            score_d = 14'd0;
            combo_d = 14'd0;
            max_d   = 14'd0;
        end else begin
            if (judge_miss) begin
                combo_d = 14'd0;
                miss_d  = 1'b1;
            end
            if (judge_hit) begin
                combo_d = combo_inc;
                score_d = score_sum;
                hit_d   = 1'b1;
                if (combo_inc > max_q) max_d = combo_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= FSM_IDLE;
            target_q     <= 4'b0;
            cnt_q        <= '0;
            btn_q        <= 4'b0;
            prev_state_q <= STATE_MENU;
            score_q      <= 14'd0;
            combo_q      <= 14'd0;
            max_q        <= 14'd0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            btn_q        <= btn;
            prev_state_q <= state;
            score_q      <= score_d;
            combo_q      <= combo_d;
            max_q        <= max_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign score      = score_q;
    assign comboCount = combo_q;
    assign max_combo  = max_q;
    assign hit        = hit_q;
    assign miss       = miss_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed and randomized self-checking bench for score_keeper
module tb_score_keeper;
    import score_keeper_pkg::*;

    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  state = STATE_GAME;
    logic        beat = 1'b0;
    logic [4:0]  arrow = ARROW_REST;
    logic [3:0]  btn = 4'b0;
    logic [13:0] score, comboCount, max_combo;
    logic        hit, miss;

    int n_checks = 0;
    int n_errors = 0;

    score_keeper #(.WINDOW_CYCLES(WIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .beat       (beat),
        .arrow      (arrow),
        .btn        (btn),
        .score      (score),
        .comboCount (comboCount),
        .max_combo  (max_combo),
        .hit        (hit),
        .miss       (miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: a pending arrow is remembered with the edge index at which it expires.
    int       cyc = 0;
    int       m_score = 0, m_combo = 0, m_max = 0, m_deadline = 0;
    bit       m_hit = 0, m_miss = 0, m_armed = 0;
    logic [3:0] m_target = 0, m_btn_prev = 0;
    logic [2:0] m_prev_state = STATE_MENU;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin : ref_model
        int s, c, mx, dl;
        bit arm, h, m;
        logic [3:0] tgt, pr;
        if (rst) begin
            m_score <= 0; m_combo <= 0; m_max <= 0; m_hit <= 0; m_miss <= 0;
            m_armed <= 0; m_target <= 0; m_deadline <= 0; m_btn_prev <= 0;
            m_prev_state <= STATE_MENU;
        end else begin
            s = m_score; c = m_combo; mx = m_max; arm = m_armed; tgt = m_target;
            dl = m_deadline; h = 0; m = 0;
            pr = btn & ~m_btn_prev;
            if (state != STATE_GAME) begin
                arm = 0;
            end else if (m_prev_state != STATE_GAME && m_prev_state != STATE_PAUSE) begin
                s = 0; c = 0; mx = 0; arm = 0;
            end else begin
                if (beat) begin
                    m = arm;
                    arm = 0;
                    if (!arrow[4]) begin
                        if (pr == 0) begin arm = 1; tgt = arrow[3:0]; dl = cyc + WIN; end
                        else if (pr == arrow[3:0]) h = 1;
                        else m = 1;
                    end
                end else if (arm) begin
                    if (pr != 0) begin arm = 0; if (pr == tgt) h = 1; else m = 1; end
                    else if (cyc == dl) begin arm = 0; m = 1; end
                end
                if (m) c = 0;
                if (h) begin
                    s = s + 10 + ((c >= 10) ? 5 : 0);
                    if (s > 9999) s = 9999;
                    c = (c + 1 > 9999) ? 9999 : c + 1;
                    if (c > mx) mx = c;
                end
            end
            m_score <= s; m_combo <= c; m_max <= mx; m_hit <= h; m_miss <= m;
            m_armed <= arm; m_target <= tgt; m_deadline <= dl;
            m_btn_prev <= btn; m_prev_state <= state;
        end
    end

    always @(negedge clk) begin
        check("score", 32'(score), m_score);
        check("comboCount", 32'(comboCount), m_combo);
        check("max_combo", 32'(max_combo), m_max);
        check("hit", 32'(hit), 32'(m_hit));
        check("miss", 32'(miss), 32'(m_miss));
    end

    task automatic step(input logic b, input logic [4:0] a, input logic [3:0] bt);
        beat = b; arrow = a; btn = bt;
        @(posedge clk);
        #2;
    endtask

    logic [4:0] arrows [5];
    int r;

    initial begin
        arrows[0] = ARROW_UP; arrows[1] = ARROW_DOWN; arrows[2] = ARROW_LEFT;
        arrows[3] = ARROW_RIGHT; arrows[4] = ARROW_REST;
        #12;
        check("reset_score", 32'(score), 0);
        check("reset_combo", 32'(comboCount), 0);
        check("reset_strobes", {30'b0, hit, miss}, 0);
        @(posedge clk); #2;
        rst = 0;
        step(0, ARROW_REST, 4'b0);

        // clean hit two cycles after the beat
        step(1, ARROW_UP, 4'b0);
        step(0, ARROW_REST, 4'b0);
        step(0, ARROW_REST, 4'b0001);
        check("clean_hit", 32'(hit), 1);
        check("clean_score", 32'(score), 10);
        check("clean_combo", 32'(comboCount), 1);
        check("clean_max", 32'(max_combo), 1);
        step(0, ARROW_REST, 4'b0001);
        check("held_btn_no_hit", 32'(hit), 0);
        step(0, ARROW_REST, 4'b0);

        // timeout four edges after the beat
        step(1, ARROW_LEFT, 4'b0);
        for (int k = 1; k <= WIN; k++) begin
            step(0, ARROW_REST, 4'b0);
            check("timeout_miss", 32'(miss), (k == WIN) ? 1 : 0);
        end
        check("timeout_combo", 32'(comboCount), 0);
        check("timeout_score", 32'(score), 10);

        // wrong / multiple press, then press in DONE
        step(1, ARROW_UP, 4'b0001);
        step(0, ARROW_REST, 4'b0);
        step(1, ARROW_DOWN, 4'b0);
        step(0, ARROW_REST, 4'b0011);
        check("multi_miss", 32'(miss), 1);
        check("multi_combo", 32'(comboCount), 0);
        check("multi_score", 32'(score), 20);
        step(0, ARROW_REST, 4'b0);
        step(0, ARROW_REST, 4'b0001);
        check("done_press_quiet", {30'b0, hit, miss}, 0);
        step(0, ARROW_REST, 4'b0);

        // beat over an unjudged arrow with a matching press
        step(1, ARROW_UP, 4'b0);
        step(0, ARROW_REST, 4'b0);
        step(1, ARROW_RIGHT, 4'b1000);
        check("overlap_strobes", {30'b0, hit, miss}, 3);
        check("overlap_combo", 32'(comboCount), 1);
        check("overlap_score", 32'(score), 30);
        step(0, ARROW_REST, 4'b0);

        // pause mid-window discards the arrow
        step(1, ARROW_LEFT, 4'b0);
        state = STATE_PAUSE;
        step(0, ARROW_REST, 4'b0100);
        check("pause_quiet", {30'b0, hit, miss}, 0);
        for (int k = 0; k < 4; k++) step(0, ARROW_REST, 4'b0);
        state = STATE_GAME;
        for (int k = 0; k < 6; k++) begin
            step(0, ARROW_REST, 4'b0);
            check("resume_no_miss", 32'(miss), 0);
        end
        check("resume_score", 32'(score), 30);
        check("resume_combo", 32'(comboCount), 1);

        // entering game from another state clears
        state = STATE_OVER;
        step(0, ARROW_REST, 4'b0);
        state = STATE_GAME;
        step(0, ARROW_REST, 4'b0);
        check("clear_score", 32'(score), 0);
        check("clear_combo", 32'(comboCount), 0);
        check("clear_max", 32'(max_combo), 0);

        // bonus and saturation
        for (int k = 0; k < 10; k++) begin
            step(1, ARROW_UP, 4'b0001);
            step(0, ARROW_REST, 4'b0);
        end
        check("ten_hits_score", 32'(score), 100);
        step(1, ARROW_DOWN, 4'b0010);
        check("bonus_score", 32'(score), 115);
        check("bonus_combo", 32'(comboCount), 11);
        step(0, ARROW_REST, 4'b0);
        for (int k = 0; k < 658; k++) begin
            step(1, ARROW_RIGHT, 4'b1000);
            step(0, ARROW_REST, 4'b0);
        end
        check("long_run_score", 32'(score), 9985);
        step(1, ARROW_UP, 4'b0010);
        step(0, ARROW_REST, 4'b0);
        step(1, ARROW_UP, 4'b0001);
        check("preload_score", 32'(score), 9995);
        step(0, ARROW_REST, 4'b0);
        step(1, ARROW_UP, 4'b0001);
        check("sat_score", 32'(score), 9999);
        check("sat_combo", 32'(comboCount), 2);
        check("sat_max", 32'(max_combo), 669);
        step(0, ARROW_REST, 4'b0);

        // async reset mid-window
        step(1, ARROW_LEFT, 4'b0);
        step(0, ARROW_REST, 4'b0);
        #1 rst = 1;
        #1;
        check("async_score", 32'(score), 0);
        check("async_max", 32'(max_combo), 0);
        check("async_strobes", {30'b0, hit, miss}, 0);
        @(posedge clk); #2;
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, ARROW_REST, 4'b0);
            check("after_reset_no_miss", 32'(miss), 0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 4) begin
                rst = 1;
                step(0, ARROW_REST, btn);
                rst = 0;
            end else begin
                if (state != STATE_GAME) begin
                    if ($urandom_range(0, 3) == 0) state = STATE_GAME;
                end else if (r < 14) begin
                    state = (r < 10) ? STATE_PAUSE : ((r < 12) ? STATE_MENU : STATE_OVER);
                end
                r = $urandom_range(0, 9);
                if (r < 3)      btn = 4'b0001 << $urandom_range(0, 3);
                else if (r < 5) btn = 4'b0;
                else if (r < 6) btn = 4'($urandom_range(0, 15));
                step(($urandom_range(0, 3) == 0), arrows[$urandom_range(0, 4)], btn);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
